// File: rtl/rv32m_pkg.sv
// rv32m_pkg: shared M-extension func3 codes, FSM states and result constants.
package rv32m_pkg;
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;
  localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: applies the latched result sign to the magnitude result and picks the architectural output.
module muldiv_sign_fix
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2*XLEN-1:0] i_acc,
  input  logic [2:0]        i_func3,
  input  logic              i_neg,
  input  logic              i_div0,
  output logic [XLEN-1:0]   o_result
);
  logic [2*XLEN-1:0] w_p;
  logic [XLEN-1:0]   w_q;
  logic [XLEN-1:0]   w_r;
  always_comb begin
    w_p      = i_neg ? -i_acc : i_acc;
    w_q      = i_div0 ? DIV0_Q : (i_neg ? -i_acc[XLEN-1:0] : i_acc[XLEN-1:0]);
    w_r      = i_neg ? -i_acc[2*XLEN-1:XLEN] : i_acc[2*XLEN-1:XLEN];
    o_result = !i_func3[2] ? ((i_func3 == F3_MUL) ? w_p[XLEN-1:0] : w_p[2*XLEN-1:XLEN])
                           : (i_func3[1] ? w_r : w_q);
  end
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: fixed 34-cycle iterative RV32M multiply/divide engine for the EX stage.
module ex_muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_valid,
  input  logic [2:0]      i_func3,
  input  logic [XLEN-1:0] i_data1,
  input  logic [XLEN-1:0] i_data2,
  input  logic [4:0]      i_write_address,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_result_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_out_write_address
);
  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_func3;
  logic [XLEN-1:0]   r_b;
  logic [2*XLEN-1:0] r_acc;
  logic              r_neg, r_div0;
  logic [4:0]        r_rd;
  logic              w_accept, w_s1, w_s2;
  logic [XLEN-1:0]   w_a, w_b, w_rem, w_fix;
  logic [XLEN:0]     w_sum, w_shl, w_diff;

  assign o_busy = r_state != ST_IDLE;

  // Operand sign handling: MULHSU treats Data2 as unsigned, the *U forms both.
  always_comb begin
    w_accept = r_state == ST_IDLE && i_valid && !i_flush;
    w_s1     = i_data1[XLEN-1] && !(i_func3 == F3_MULHU || i_func3 == F3_DIVU || i_func3 == F3_REMU);
    w_s2     = i_data2[XLEN-1] && (i_func3 == F3_MUL || i_func3 == F3_MULH || i_func3 == F3_DIV || i_func3 == F3_REM);
    w_a      = w_s1 ? -i_data1 : i_data1;
    w_b      = w_s2 ? -i_data2 : i_data2;
    w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_shl    = r_acc[2*XLEN-1:XLEN-1];
    w_diff   = w_shl - {1'b0, r_b};
    w_rem    = w_diff[XLEN] ? w_shl[XLEN-1:0] : w_diff[XLEN-1:0];
  end

  always_comb begin
    w_next = r_state;
    if (i_flush) w_next = ST_IDLE;
    else if (r_state == ST_IDLE && i_valid) w_next = i_func3[2] ? ST_DIV : ST_MUL;
    else if ((r_state == ST_MUL || r_state == ST_DIV) && &r_cnt) w_next = ST_FIX;
    else if (r_state == ST_FIX) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= ST_IDLE;
    else r_state <= w_next;

  // Accumulator: MUL keeps {partial product, multiplier}, DIV keeps {remainder, dividend/quotient}.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt               <= '0;
      r_func3             <= '0;
      r_b                 <= '0;
      r_acc               <= '0;
      r_neg               <= 1'b0;
      r_div0              <= 1'b0;
      r_rd                <= '0;
      o_result            <= '0;
      o_result_valid      <= 1'b0;
      o_out_write_address <= '0;
    end else begin
      o_result_valid <= 1'b0;
      if (w_accept) begin
        r_cnt   <= '0;
        r_func3 <= i_func3;
        r_rd    <= i_write_address;
        r_b     <= i_func3[2] ? w_b : w_a;
        r_acc   <= {{XLEN{1'b0}}, i_func3[2] ? w_a : w_b};
        r_neg   <= (i_func3[2] && i_func3[1]) ? w_s1 : w_s1 ^ w_s2;
        r_div0  <= i_data2 == '0;
      end else if (r_state == ST_MUL || r_state == ST_DIV) begin
        r_acc <= (r_state == ST_MUL) ? {w_sum, r_acc[XLEN-1:1]} : {w_rem, r_acc[XLEN-2:0], ~w_diff[XLEN]};
        r_cnt <= &r_cnt ? r_cnt : r_cnt + 1'b1;
      end else if (r_state == ST_FIX && !i_flush) begin
        o_result            <= w_fix;
        o_result_valid      <= 1'b1;
        o_out_write_address <= r_rd;
      end
    end
  end

  muldiv_sign_fix #(.XLEN(XLEN)) u_fix (
    .i_acc   (r_acc),
    .i_func3 (r_func3),
    .i_neg   (r_neg),
    .i_div0  (r_div0),
    .o_result(w_fix)
  );
endmodule
